// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Contents: arbiter state enum, word size in bytes, default parameter values.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    CPU_OWN   = 1'b0,
    EXT_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned DEF_LEN_W    = 8;
  localparam int unsigned DEF_MAX_WAIT = 16;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// External loader/debug burst port of the data-memory arbiter.
// master: loader side (drives request, direction, address, length, write data)
// slave : arbiter side (drives grant, read-data valid, read data, done pulse)
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
);

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [LEN_W-1:0]  ext_len;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_done;

  modport master (
    output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata, ext_done
  );

  modport slave (
    input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata, ext_done
  );

endinterface

// File: rtl/dmem_port_arbiter_burst.sv
// Burst address generator and beat down-counter.
// Ports: clk, reset (sync, active-low), load (capture base/len), step (one beat
// done), loadAddr/loadLen (burst base and length), addr (current beat address),
// last (current beat is the final one).
module dmem_burst_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [LEN_W-1:0]  loadLen,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addrQ;
  logic [LEN_W-1:0]  beatCnt;

  // A zero-length request still performs one beat; address wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addrQ   <= '0;
      beatCnt <= '0;
    end else if (load) begin
      addrQ   <= loadAddr;
      beatCnt <= (loadLen == '0) ? LEN_W'(1) : loadLen;
    end else if (step) begin
      addrQ   <= addrQ + ADDR_W'(WORD_BYTES);
      beatCnt <= beatCnt - LEN_W'(1);
    end
  end

  assign addr = addrQ;
  assign last = (beatCnt == LEN_W'(1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage and an
// external loader/debug burst port. The CPU owns the port by default; an
// external burst is granted on a CPU-idle cycle and then runs one beat per
// cycle, stalling the CPU only when it actually needs memory.
// Ports: clk, reset (sync, active-low); cpu_* from EX/MEM and load data /
// stall back to the pipeline; ext (burst port interface, slave side);
// mem_* to/from datamemory (combinational read, write at clk edge).
// Optional build macro ARB_STARVATION_GUARD_EN: forces a grant after MAX_WAIT
// refused request cycles even when the CPU is busy.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
`ifdef ARB_STARVATION_GUARD_EN
  , parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memRead,
  input  logic              cpu_memWrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_writeData,
  output logic [DATA_W-1:0] cpu_readData,
  output logic              cpu_stall,
  dmem_port_arbiter_if.slave ext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_readData
);

  arb_state_e        state;
  arb_state_e        nextState;
  logic              grant;
  logic              inBurst;
  logic              cpuBusy;
  logic              extReqLive;
  logic              forceGrant;
  logic              extWeQ;
  logic              doneQ;
  logic              rvalidQ;
  logic [DATA_W-1:0] rdataQ;
  logic [ADDR_W-1:0] burstAddr;
  logic              burstLast;

  assign cpuBusy    = cpu_memRead | cpu_memWrite;
  assign inBurst    = (state == EXT_BURST);
  // Requests are ignored in the done cycle so bursts are never back to back.
  assign extReqLive = ext.ext_req & ~doneQ;

`ifdef ARB_STARVATION_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] waitCnt;

  // Counts cycles the CPU keeps the port while an external request is pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (!extReqLive || grant || inBurst) begin
      waitCnt <= '0;
    end else if (waitCnt != WAIT_W'(MAX_WAIT)) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  assign forceGrant = (waitCnt == WAIT_W'(MAX_WAIT));
`else
  assign forceGrant = 1'b0;
`endif

  dmem_burst_counter #(.LEN_W(LEN_W)) u_burst (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .step     (inBurst),
    .loadAddr (ext.ext_addr),
    .loadLen  (ext.ext_len),
    .addr     (burstAddr),
    .last     (burstLast)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CPU_OWN;
    end else begin
      state <= nextState;
    end
  end

  // Next state and memory-port steering.
  always_comb begin
    nextState     = state;
    grant         = 1'b0;
    cpu_stall     = 1'b0;
    mem_addr      = cpu_addr;
    mem_writeData = cpu_writeData;
    mem_memRead   = cpu_memRead;
    mem_memWrite  = cpu_memWrite;
    case (state)
      CPU_OWN: begin
        // A forced grant lets this cycle's CPU access finish first.
        if (extReqLive && (!cpuBusy || forceGrant)) begin
          grant     = 1'b1;
          nextState = EXT_BURST;
        end
      end
      EXT_BURST: begin
        mem_addr      = burstAddr;
        mem_writeData = ext.ext_wdata;
        mem_memRead   = ~extWeQ;
        mem_memWrite  = extWeQ;
        cpu_stall     = cpuBusy;
        if (burstLast) begin
          nextState = CPU_OWN;
        end
      end
      default: nextState = CPU_OWN;
    endcase
  end

  // Burst direction, done pulse and one-cycle-late read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      extWeQ  <= 1'b0;
      doneQ   <= 1'b0;
      rvalidQ <= 1'b0;
      rdataQ  <= '0;
    end else begin
      if (grant) begin
        extWeQ <= ext.ext_we;
      end
      doneQ   <= inBurst & burstLast;
      rvalidQ <= inBurst & ~extWeQ;
      if (inBurst && !extWeQ) begin
        rdataQ <= mem_readData;
      end
    end
  end

  assign cpu_readData   = mem_readData;
  assign ext.ext_gnt    = inBurst;
  assign ext.ext_rvalid = rvalidQ;
  assign ext.ext_rdata  = rdataQ;
  assign ext.ext_done   = doneQ;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a per-cycle vector table for bursts,
// stalls and address corner cases, then hand sequences for starvation handling
// and reset in the middle of a burst. A 64-word memory model sits on mem_*.
module tb_dmem_port_arbiter;

  typedef struct {
    logic [31:0] cRd, cWr, cAddr, cWd;
    logic [31:0] eReq, eWe, eAddr, eLen, eWd;
    logic [31:0] gnt, stall, rvalid, rdata, done;
    logic [31:0] mRd, mWr, mAddr, mWd;
    logic [31:0] chkCrd, crd;
  } vec_t;

  localparam int NVEC = 22;

  logic        clk;
  logic        reset;
  logic        cpuMemRead;
  logic        cpuMemWrite;
  logic [31:0] cpuAddr;
  logic [31:0] cpuWriteData;
  logic [31:0] cpuReadData;
  logic        cpuStall;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memMemRead;
  logic        memMemWrite;
  logic [31:0] memReadData;
  logic [31:0] memArr [64];

  int   nChecks;
  int   nFail;
  int   loadsAll;
  int   loadsLw;
  int   got;
  int   n;
  vec_t vecs [NVEC];

  dmem_port_arbiter_if #(.LEN_W(8)) ext ();

  dmem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_memRead   (cpuMemRead),
    .cpu_memWrite  (cpuMemWrite),
    .cpu_addr      (cpuAddr),
    .cpu_writeData (cpuWriteData),
    .cpu_readData  (cpuReadData),
    .cpu_stall     (cpuStall),
    .ext           (ext),
    .mem_addr      (memAddr),
    .mem_writeData (memWriteData),
    .mem_memRead   (memMemRead),
    .mem_memWrite  (memMemWrite),
    .mem_readData  (memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write at the clock edge.
  assign memReadData = memArr[memAddr[7:2]];
  always @(posedge clk) begin
    if (memMemWrite) memArr[memAddr[7:2]] <= memWriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyIn(input vec_t v);
    cpuMemRead    = v.cRd[0];
    cpuMemWrite   = v.cWr[0];
    cpuAddr       = v.cAddr;
    cpuWriteData  = v.cWd;
    ext.ext_req   = v.eReq[0];
    ext.ext_we    = v.eWe[0];
    ext.ext_addr  = v.eAddr;
    ext.ext_len   = 8'(v.eLen);
    ext.ext_wdata = v.eWd;
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    for (int i = 0; i < 64; i++) memArr[i] = '0;

    //           cRd cWr cAddr cWd  eReq eWe eAddr        eLen eWd    gnt stl rv rdata done mRd mWr mAddr        mWd    chk crd
    vecs[0]  = '{0, 0, 0,     0,   1, 1, 'h40,        3,   0,     0, 0, 0, 0,  0,   0, 0, 0,           0,     1, 0};
    vecs[1]  = '{0, 0, 0,     0,   1, 1, 'h40,        3,   11,    1, 0, 0, 0,  0,   0, 1, 'h40,        11,    0, 0};
    vecs[2]  = '{0, 0, 0,     0,   0, 1, 'h40,        3,   22,    1, 0, 0, 0,  0,   0, 1, 'h44,        22,    0, 0};
    vecs[3]  = '{0, 0, 0,     0,   0, 1, 'h40,        3,   33,    1, 0, 0, 0,  0,   0, 1, 'h48,        33,    0, 0};
    vecs[4]  = '{0, 0, 0,     0,   1, 0, 'h40,        3,   0,     0, 0, 0, 0,  1,   0, 0, 0,           0,     1, 0};
    vecs[5]  = '{0, 0, 0,     0,   1, 0, 'h40,        3,   0,     0, 0, 0, 0,  0,   0, 0, 0,           0,     1, 0};
    vecs[6]  = '{0, 0, 0,     0,   1, 0, 'h40,        3,   0,     1, 0, 0, 0,  0,   1, 0, 'h40,        0,     0, 0};
    vecs[7]  = '{0, 0, 0,     0,   0, 0, 'h40,        3,   0,     1, 0, 1, 11, 0,   1, 0, 'h44,        0,     0, 0};
    vecs[8]  = '{0, 0, 0,     0,   0, 0, 'h40,        3,   0,     1, 0, 1, 22, 0,   1, 0, 'h48,        0,     0, 0};
    vecs[9]  = '{0, 0, 0,     0,   0, 0, 'h40,        3,   0,     0, 0, 1, 33, 1,   0, 0, 0,           0,     1, 0};
    vecs[10] = '{0, 0, 0,     0,   1, 1, 'h80,        2,   0,     0, 0, 0, 33, 0,   0, 0, 0,           0,     1, 0};
    vecs[11] = '{1, 0, 'h80,  0,   0, 1, 'h80,        2,   'hAA,  1, 1, 0, 33, 0,   0, 1, 'h80,        'hAA,  0, 0};
    vecs[12] = '{1, 0, 'h80,  0,   0, 1, 'h80,        2,   'hBB,  1, 1, 0, 33, 0,   0, 1, 'h84,        'hBB,  0, 0};
    vecs[13] = '{1, 0, 'h80,  0,   0, 1, 'h80,        2,   0,     0, 0, 0, 33, 1,   1, 0, 'h80,        0,     1, 'hAA};
    vecs[14] = '{0, 0, 0,     0,   1, 1, 'h20,        0,   0,     0, 0, 0, 33, 0,   0, 0, 0,           0,     1, 0};
    vecs[15] = '{0, 0, 0,     0,   0, 1, 'h20,        0,   'h55,  1, 0, 0, 33, 0,   0, 1, 'h20,        'h55,  0, 0};
    vecs[16] = '{0, 0, 0,     0,   0, 1, 'h20,        0,   0,     0, 0, 0, 33, 1,   0, 0, 0,           0,     0, 0};
    vecs[17] = '{0, 0, 0,     0,   1, 1, 'hFFFFFFFC,  2,   0,     0, 0, 0, 33, 0,   0, 0, 0,           0,     0, 0};
    vecs[18] = '{0, 0, 0,     0,   0, 1, 'hFFFFFFFC,  2,   'hC1,  1, 0, 0, 33, 0,   0, 1, 'hFFFFFFFC,  'hC1,  0, 0};
    vecs[19] = '{0, 0, 0,     0,   0, 1, 'hFFFFFFFC,  2,   'hC2,  1, 0, 0, 33, 0,   0, 1, 0,           'hC2,  0, 0};
    vecs[20] = '{0, 0, 0,     0,   0, 0, 0,           0,   0,     0, 0, 0, 33, 1,   0, 0, 0,           0,     1, 'hC2};
    vecs[21] = '{1, 0, 'hFC,  0,   0, 0, 0,           0,   0,     0, 0, 0, 33, 0,   1, 0, 'hFC,        0,     1, 'hC1};

    // Reset
    reset = 1'b0;
    applyIn('{default: 0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ext_gnt",    32'(ext.ext_gnt),    0);
    check("reset ext_rvalid", 32'(ext.ext_rvalid), 0);
    check("reset ext_done",   32'(ext.ext_done),   0);
    check("reset cpu_stall",  32'(cpuStall),       0);
    check("reset ext_rdata",  ext.ext_rdata,       0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Vector table
    loadsAll = 0;
    loadsLw  = 0;
    for (int i = 0; i < NVEC; i++) begin
      applyIn(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d ext_gnt", i),       32'(ext.ext_gnt),    vecs[i].gnt);
      check($sformatf("row%0d cpu_stall", i),     32'(cpuStall),       vecs[i].stall);
      check($sformatf("row%0d ext_rvalid", i),    32'(ext.ext_rvalid), vecs[i].rvalid);
      check($sformatf("row%0d ext_rdata", i),     ext.ext_rdata,       vecs[i].rdata);
      check($sformatf("row%0d ext_done", i),      32'(ext.ext_done),   vecs[i].done);
      check($sformatf("row%0d mem_memRead", i),   32'(memMemRead),     vecs[i].mRd);
      check($sformatf("row%0d mem_memWrite", i),  32'(memMemWrite),    vecs[i].mWr);
      check($sformatf("row%0d mem_addr", i),      memAddr,             vecs[i].mAddr);
      check($sformatf("row%0d mem_writeData", i), memWriteData,        vecs[i].mWd);
      if (vecs[i].chkCrd[0]) begin
        check($sformatf("row%0d cpu_readData", i), cpuReadData, vecs[i].crd);
      end
      if (vecs[i].cRd[0] && !cpuStall) begin
        loadsAll++;
        if (i >= 11 && i <= 13) loadsLw++;
      end
      @(posedge clk); #1;
    end
    check("lw writebacks during burst", 32'(loadsLw),  1);
    check("total load writebacks",      32'(loadsAll), 2);
    check("wrap word at 0x00000000",    memArr[0],     'hC2);
    check("len0 single beat at 0x20",   memArr[8],     'h55);
    check("len0 no second beat 0x24",   memArr[9],     0);

    // Busy CPU with a pending external request
    cpuMemRead   = 1'b1;
    cpuAddr      = 'h44;
    ext.ext_req  = 1'b1;
    ext.ext_we   = 1'b0;
    ext.ext_addr = 'h40;
    ext.ext_len  = 8'd1;
    got = 0;
    n   = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ext.ext_gnt) begin
        got = 1;
        n   = i;
        break;
      end
      @(posedge clk); #1;
    end
`ifdef ARB_STARVATION_GUARD_EN
    check("forced grant seen",        32'(got),      1);
    check("forced grant cycle",       32'(n),        17);
    check("stall during forced beat", 32'(cpuStall), 1);
    @(posedge clk); #1;
    ext.ext_req = 1'b0;
    cpuMemRead  = 1'b0;
`else
    check("no grant while cpu busy", 32'(got), 0);
    cpuMemRead = 1'b0;
    @(negedge clk);
    check("idle decision cycle gnt", 32'(ext.ext_gnt), 0);
    @(posedge clk); #1;
    ext.ext_req = 1'b0;
    @(negedge clk);
    check("gnt after cpu idle", 32'(ext.ext_gnt), 1);
    @(posedge clk); #1;
`endif
    repeat (3) @(posedge clk);
    #1;

    // Reset during beat 2 of a 4-beat write burst
    ext.ext_req   = 1'b1;
    ext.ext_we    = 1'b1;
    ext.ext_addr  = 'h60;
    ext.ext_len   = 8'd4;
    ext.ext_wdata = 'h77;
    @(posedge clk); #1;
    ext.ext_req = 1'b0;
    @(negedge clk);
    check("rst seq beat1 gnt", 32'(ext.ext_gnt), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst seq beat2 gnt", 32'(ext.ext_gnt), 1);
    check("rst seq beat2 addr", memAddr, 'h64);
    @(posedge clk); #1;
    reset      = 1'b1;
    cpuMemRead = 1'b1;
    cpuAddr    = 'h40;
    @(negedge clk);
    check("post-reset gnt",       32'(ext.ext_gnt),  0);
    check("post-reset stall",     32'(cpuStall),     0);
    check("post-reset memRead",   32'(memMemRead),   1);
    check("post-reset ext_rdata", ext.ext_rdata,     0);
    check("post-reset done",      32'(ext.ext_done), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("aborted burst done c%0d", i), 32'(ext.ext_done), 0);
      check($sformatf("aborted burst gnt c%0d", i),  32'(ext.ext_gnt),  0);
    end
    cpuMemRead = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
